// File: rtl/tableau_fifo_reader_if.sv
// AXI-Stream style bundle carrying tableau elements between blocks.
// The master side drives data, valid and tags; the slave side returns ready.
interface tableau_fifo_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [2:0]            tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  // The source FIFO carries bare elements, so the consumer side sees no tags.
  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/tableau_fifo_reader.sv
// Streams a stored tableau out of the DDR-side FIFO toward the pivot/update
// datapath, tagging each element with objective-row, RHS-column and row-end
// flags and marking the final element with TLAST. One pass per start pulse,
// up to one element per cycle through a single registered output stage.
module tableau_fifo_reader #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start,
  input  logic [15:0]            tableau_num_cols,
  input  logic [31:0]            tableau_total_size,
  output logic                   busy,
  output logic                   done,
  input  logic                   rst_busy_src,
  tableau_fifo_reader_if.slave   s_axis,
  tableau_fifo_reader_if.master  m_axis
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [15:0] num_cols;
  logic [31:0] total_size;
  logic [31:0] elem_cnt;
  logic [15:0] col_cnt;

  logic src_ready;
  logic accept;
  logic tag_obj;
  logic tag_rhs;
  logic tag_last;
  logic degenerate;

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic [2:0]            out_user;

  // Tags come from the counts before this element is counted; the degenerate
  // test looks at the live inputs because they are latched on the start edge.
  always_comb begin
    tag_obj    = elem_cnt < {16'd0, num_cols};
    tag_rhs    = col_cnt == (num_cols - 16'd1);
    tag_last   = elem_cnt == (total_size - 32'd1);
    degenerate = (tableau_num_cols == 16'd0) || (tableau_total_size == 32'd0);
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a pass ends once the last element is accepted and the
  // output register has been handed downstream.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !rst_busy_src) begin
          state_next = degenerate ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept && tag_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid || m_axis.tready) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs and the source pop strobe; ready feeds through from the
  // sink so a full output register can be refilled in the cycle it empties.
  always_comb begin
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE);
    src_ready = (state == RUN) && !rst_busy_src && (!out_valid || m_axis.tready);
    accept    = s_axis.tvalid && src_ready;
  end

  // Capture the pass geometry when a start is accepted.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      num_cols   <= 16'd0;
      total_size <= 32'd0;
    end else if ((state == IDLE) && start && !rst_busy_src) begin
      num_cols   <= tableau_num_cols;
      total_size <= tableau_total_size;
    end
  end

  // Element and column counters advance only on an accepted element.
  always_ff @(posedge aclk) begin
    if (!aresetn || (state == IDLE)) begin
      elem_cnt <= 32'd0;
      col_cnt  <= 16'd0;
    end else if (accept) begin
      elem_cnt <= elem_cnt + 32'd1;
      col_cnt  <= tag_rhs ? 16'd0 : col_cnt + 16'd1;
    end
  end

  // Output register: load on accept, hold while stalled, empty on a pop.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_user  <= 3'd0;
    end else if (accept) begin
      out_data  <= s_axis.tdata;
      out_valid <= 1'b1;
      out_last  <= tag_last;
      out_user  <= {tag_rhs, tag_rhs, tag_obj};
    end else if (m_axis.tready) begin
      out_valid <= 1'b0;
    end
  end

  assign s_axis.tready = src_ready;
  assign m_axis.tdata  = out_data;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_last;
  assign m_axis.tuser  = out_user;

endmodule
